i2c_slave_responder: RTL
========================

I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 8, meaning the data byte width.
REQ-002 The module SHALL have parameter ADDR_SIZE, default 7, meaning the slave address width.
REQ-003 The module SHALL have port i2c_core_clk_i, input, 1 bit: core clock; all state SHALL change on its rising edge.
REQ-004 The module SHALL have port reset_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port scl_i, input, 1 bit: raw SCL line level.
REQ-006 The module SHALL have port sda_i, input, 1 bit: raw SDA line level.
REQ-007 The module SHALL have port own_addr_i, input, ADDR_SIZE bits: this slave's address.
REQ-008 The module SHALL have port tx_data_i, input, DATA_SIZE bits: byte returned on master reads.
REQ-009 The module SHALL have port rx_ready_i, input, 1 bit: core can accept a received byte.
REQ-010 The module SHALL have port sda_low_o, output, 1 bit: 1 = pull SDA low (open-drain).
REQ-011 The module SHALL have port rx_data_o, output, DATA_SIZE bits: last received byte.
REQ-012 The module SHALL have port rx_valid_o, output, 1 bit: one-cycle pulse when rx_data_o is updated.
REQ-013 The module SHALL have port tx_load_o, output, 1 bit: one-cycle pulse when tx_data_i is sampled.
REQ-014 The module SHALL have port busy_o, output, 1 bit: 1 while addressed, from address ACK until STOP, START or NACK.

Function
REQ-015 scl_i and sda_i SHALL each pass a 2-flop synchronizer; edges SHALL be detected on stage-2 against a registered copy.
REQ-016 START (SDA fall while SCL high) and STOP (SDA rise while SCL high) SHALL be detected in every state and SHALL take priority over bit events in the same cycle.
REQ-017 FSM states: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE.
REQ-018 START in any state -> ADDR with bit counter cleared and sda_low_o=0 (repeated START supported); STOP in any state -> IDLE with sda_low_o=0.
REQ-019 Bits SHALL be sampled MSB first on synchronized SCL rising edges; sda_low_o SHALL change only on synchronized SCL falling edges.
REQ-020 The latency from a raw scl_i fall to the sda_low_o update SHALL be 3 clock edges.
REQ-021 ADDR: after 8 samples ({addr, R/W}), a match goes to ADDR_ACK, a mismatch goes to IGNORE (SDA released until START/STOP).
REQ-022 ADDR_ACK: sda_low_o=1 from the next SCL fall to the following SCL fall; busy_o=1; next state RX_DATA (R/W=0) or TX_DATA (R/W=1).
REQ-023 On entry to TX_DATA, and on each master ACK: tx_data_i SHALL be latched with a tx_load_o pulse in the same cycle, and sda_low_o=~bit[7] on that SCL fall.
REQ-024 TX_DATA: each subsequent SCL fall shifts out the next bit; after bit 0 the SDA is released (sda_low_o=0), then TX_ACK.
REQ-025 TX_ACK: SDA sampled on SCL rise; 0 (ACK) -> TX_DATA, 1 (NACK) -> IGNORE with busy_o=0.
REQ-026 RX_DATA: on the 8th SCL rise, rx_data_o SHALL update with a 1-cycle rx_valid_o pulse, then RX_ACK.
REQ-027 RX_ACK: on the next SCL fall, sda_low_o=rx_ready_i (captured at that fall), released on the following fall, then RX_DATA.
REQ-028 The bit counter SHALL wrap 7->0 per byte; an unlimited number of bytes per transfer SHALL be supported.
REQ-029 SDA activity while SCL is high outside START/STOP SHALL be treated as START/STOP per REQ-016.

Reset
REQ-030 While reset_ni=0: state=IDLE, sda_low_o=0, rx_data_o=0, rx_valid_o=0, tx_load_o=0, busy_o=0, counters=0, synchronizer flops=1 (bus idle).
REQ-031 Reset asserted mid-transfer SHALL release SDA within 0 clocks (asynchronous); after release the module SHALL wait for a new START.

Verification
REQ-032 own_addr=0x50; master write 0xA0, 0x3C, STOP, rx_ready=1 -> address ACK, rx_data_o=0x3C with one rx_valid_o pulse, data ACK, busy_o=0 after STOP.
REQ-033 Master write 0xA2 (address 0x51) to own_addr=0x50 -> no ACK (sda_low_o stays 0), no rx_valid_o, state IGNORE until STOP.
REQ-034 Master read 0xA1, tx_data_i=0x96 then 0x5A, master ACK then NACK -> SDA bits 10010110, 01011010; two tx_load_o pulses; busy_o=0 after NACK.
REQ-035 Write byte 0x11 with rx_ready=0 -> rx_valid_o pulse, sda_low_o=0 in the ACK slot (NACK).
REQ-036 Repeated START after a write byte, then address 0xA1 -> re-enters ADDR, ACKs, enters TX_DATA; reset_ni pulsed mid-TX -> sda_low_o=0 immediately, IDLE.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
// Byte-oriented I2C slave front end. Synchronizes raw SCL/SDA into the core
// clock domain, decodes START/STOP, matches the slave address, ACKs it, then
// either receives bytes (ACK driven from rx_ready_i) or returns bytes taken
// from tx_data_i until the master NACKs. SDA is only ever pulled low.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | bus free or not yet started, waiting for START
// ST_ADDR     | shifting in {address, R/W} on SCL rises
// ST_ADDR_ACK | driving the address ACK (phase 0: wait fall, 1: release)
// ST_RX_DATA  | shifting in a data byte from the master
// ST_RX_ACK   | driving ACK/NACK for the received byte
// ST_TX_DATA  | shifting out a data byte on SCL falls
// ST_TX_ACK   | SDA released, sampling the master's ACK/NACK
// ST_IGNORE   | not addressed or transfer ended, SDA released until START/STOP

module i2c_slave_responder #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 7
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_ni,
  input  logic                 scl_i,
  input  logic                 sda_i,
  input  logic [ADDR_SIZE-1:0] own_addr_i,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 rx_ready_i,
  output logic                 sda_low_o,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 tx_load_o,
  output logic                 busy_o
);

  // Shift register holds every sample except the last one of a frame, which
  // is consumed directly from the synchronizer when the frame completes.
  localparam int SH_W  = (DATA_SIZE - 1 > ADDR_SIZE) ? DATA_SIZE - 1 : ADDR_SIZE;
  localparam int CNT_W = $clog2(SH_W + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_SIZE);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic                 rw_q, rw_d;
  logic [SH_W-1:0]      shift_q, shift_d;
  logic [DATA_SIZE-2:0] tx_shift_q, tx_shift_d;
  logic                 sda_low_q, sda_low_d;
  logic                 busy_q, busy_d;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tx_load;

  logic scl_s1, scl_s2, scl_q;
  logic sda_s1, sda_s2, sda_q;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;

  // Two-flop synchronizers plus a registered copy for edge detection; reset to
  // the idle-bus level so leaving reset never looks like a bus event.
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_q  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_q  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_q  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_q;
  assign scl_fall  = ~scl_s2 & scl_q;
  assign start_det = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_det  = scl_s2 & scl_q & ~sda_q & sda_s2;

  // State and datapath registers.
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Next-state and output decode; bus conditions override any bit activity.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    sda_low_d  = sda_low_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load    = 1'b0;

    if (start_det) begin
      state_d   = ST_ADDR;
      cnt_d     = '0;
      phase_d   = 1'b0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      phase_d   = 1'b0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[SH_W-2:0], sda_s2};
            if (cnt_q == ADDR_LAST) begin
              cnt_d   = '0;
              phase_d = 1'b0;
              rw_d    = sda_s2;
              state_d = (shift_q[ADDR_SIZE-1:0] == own_addr_i) ? ST_ADDR_ACK : ST_IGNORE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_low_d = 1'b1;
              busy_d    = 1'b1;
              phase_d   = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = '0;
              if (rw_q) begin
                state_d    = ST_TX_DATA;
                tx_load    = 1'b1;
                tx_shift_d = tx_data_i[DATA_SIZE-2:0];
                sda_low_d  = ~tx_data_i[DATA_SIZE-1];
              end else begin
                state_d   = ST_RX_DATA;
                sda_low_d = 1'b0;
              end
            end
          end
        end

        ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[SH_W-2:0], sda_s2};
            if (cnt_q == DATA_LAST) begin
              cnt_d      = '0;
              phase_d    = 1'b0;
              rx_data_d  = {shift_q[DATA_SIZE-2:0], sda_s2};
              rx_valid_d = 1'b1;
              state_d    = ST_RX_ACK;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_low_d = rx_ready_i;
              phase_d   = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              phase_d   = 1'b0;
              state_d   = ST_RX_DATA;
            end
          end
        end

        ST_TX_DATA: begin
          if (scl_fall) begin
            if (cnt_q == DATA_LAST) begin
              cnt_d     = '0;
              phase_d   = 1'b0;
              sda_low_d = 1'b0;
              state_d   = ST_TX_ACK;
            end else begin
              sda_low_d  = ~tx_shift_q[DATA_SIZE-2];
              tx_shift_d = {tx_shift_q[DATA_SIZE-3:0], 1'b0};
              cnt_d      = cnt_q + 1'b1;
            end
          end
        end

        ST_TX_ACK: begin
          // phase 0 waits for the master's ACK bit, phase 1 for the fall that
          // starts the next byte.
          if (!phase_q) begin
            if (scl_rise) begin
              if (sda_s2) begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end else begin
                phase_d = 1'b1;
              end
            end
          end else if (scl_fall) begin
            phase_d    = 1'b0;
            cnt_d      = '0;
            state_d    = ST_TX_DATA;
            tx_load    = 1'b1;
            tx_shift_d = tx_data_i[DATA_SIZE-2:0];
            sda_low_d  = ~tx_data_i[DATA_SIZE-1];
          end
        end

        default: begin
          // ST_IDLE and ST_IGNORE only react to START/STOP.
        end
      endcase
    end
  end

  assign sda_low_o  = sda_low_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_load_o  = tx_load;
  assign busy_o     = busy_q;

endmodule
